// File: rtl/bus_pkg.sv
// Shared frame layout, CRC polynomial and receiver state encoding for the serial bus nodes.
package bus_pkg;

   localparam int ADDR_W    = 4;
   localparam int DATA_W    = 64;
   localparam int CRC_W     = 4;
   localparam int FRAME_LEN = 74;
   localparam int CNT_W     = 7;

   localparam logic [CRC_W-1:0]  CRC_POLY   = 4'b0011;
   localparam logic [ADDR_W-1:0] BCAST_ADDR = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_CRC,
      ST_STOP
   } rx_state_t;

endpackage

// File: rtl/crc4_serial.sv
// Bit-serial CRC-4 (x^4+x+1), MSB-first, zero init; shared by bus transmitter and receiver.
module crc4_serial
   import bus_pkg::*;
(
   input  logic             clock,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             clear,
   input  logic             bit_in,
   output logic [CRC_W-1:0] crc_out
);

   logic [CRC_W-1:0] crc_reg;
   logic [CRC_W-1:0] crc_next;
   logic             feedback;

   assign feedback = crc_reg[CRC_W-1] ^ bit_in;

   generate
      for (genvar gi = 0; gi < CRC_W; gi++) begin : g_crc_bit
         if (gi == 0) begin : g_lsb
            assign crc_next[gi] = feedback & CRC_POLY[gi];
         end else begin : g_upper
            assign crc_next[gi] = crc_reg[gi-1] ^ (feedback & CRC_POLY[gi]);
         end
      end
   endgenerate

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         crc_reg <= '0;
      end else if (clear) begin
         crc_reg <= '0;
      end else if (enable) begin
         crc_reg <= crc_next;
      end
   end

   assign crc_out = crc_reg;

endmodule

// File: rtl/bus_rx_node.sv
// Serial bus frame receiver: start, ADDR, DATA, CRC-4, stop. Emits one result pulse per
// addressed or malformed frame, one cycle after the stop bit has been sampled.
module bus_rx_node #(
   parameter logic [3:0] MY_ADDR    = 4'd1,
   parameter logic [3:0] BCAST_ADDR = bus_pkg::BCAST_ADDR
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        bus_in,
   output logic [63:0] rx_data,
   output logic [3:0]  rx_addr,
   output logic        rx_valid,
   output logic        crc_err,
   output logic        frame_err,
   output logic        busy
);

   import bus_pkg::*;

   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(CRC_W - 1);

   rx_state_t         state_reg;
   logic [CNT_W-1:0]  bit_cnt_reg;
   logic [ADDR_W-1:0] addr_sr_reg;
   logic [DATA_W-1:0] data_sr_reg;
   logic [CRC_W-1:0]  crc_rx_reg;
   logic [CRC_W-1:0]  crc_calc;

   // Verdict of the frame just finished, consumed one cycle later so a new frame may already start.
   logic              eval_pending_reg;
   logic              stop_bad_reg;
   logic              match_reg;
   logic              crc_ok_reg;

   logic [DATA_W-1:0] rx_data_reg;
   logic [ADDR_W-1:0] rx_addr_reg;
   logic              rx_valid_reg;
   logic              crc_err_reg;
   logic              frame_err_reg;
   logic              busy_reg;

   logic              crc_enable;
   logic              crc_clear;

   assign crc_enable = (state_reg == ST_ADDR) || (state_reg == ST_DATA);
   assign crc_clear  = (state_reg == ST_IDLE) && bus_in;

   crc4_serial u_crc (
      .clock   (clock),
      .reset_n (reset_n),
      .enable  (crc_enable),
      .clear   (crc_clear),
      .bit_in  (bus_in),
      .crc_out (crc_calc)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg        <= ST_IDLE;
         bit_cnt_reg      <= '0;
         addr_sr_reg      <= '0;
         data_sr_reg      <= '0;
         crc_rx_reg       <= '0;
         eval_pending_reg <= 1'b0;
         stop_bad_reg     <= 1'b0;
         match_reg        <= 1'b0;
         crc_ok_reg       <= 1'b0;
         rx_data_reg      <= '0;
         rx_addr_reg      <= '0;
         rx_valid_reg     <= 1'b0;
         crc_err_reg      <= 1'b0;
         frame_err_reg    <= 1'b0;
         busy_reg         <= 1'b0;
      end else begin
         rx_valid_reg     <= 1'b0;
         crc_err_reg      <= 1'b0;
         frame_err_reg    <= 1'b0;
         eval_pending_reg <= 1'b0;

         if (eval_pending_reg) begin
            if (stop_bad_reg) begin
               frame_err_reg <= 1'b1;
            end else if (match_reg) begin
               if (crc_ok_reg) begin
                  rx_valid_reg <= 1'b1;
                  rx_data_reg  <= data_sr_reg;
                  rx_addr_reg  <= addr_sr_reg;
               end else begin
                  crc_err_reg <= 1'b1;
               end
            end
         end

         case (state_reg)
            ST_IDLE: begin
               bit_cnt_reg <= '0;
               if (bus_in) begin
                  state_reg <= ST_ADDR;
                  busy_reg  <= 1'b1;
               end
            end
            ST_ADDR: begin
               addr_sr_reg <= {addr_sr_reg[ADDR_W-2:0], bus_in};
               if (bit_cnt_reg == ADDR_LAST) begin
                  state_reg   <= ST_DATA;
                  bit_cnt_reg <= '0;
               end else begin
                  bit_cnt_reg <= bit_cnt_reg + 1'b1;
               end
            end
            ST_DATA: begin
               data_sr_reg <= {data_sr_reg[DATA_W-2:0], bus_in};
               if (bit_cnt_reg == DATA_LAST) begin
                  state_reg   <= ST_CRC;
                  bit_cnt_reg <= '0;
               end else begin
                  bit_cnt_reg <= bit_cnt_reg + 1'b1;
               end
            end
            ST_CRC: begin
               crc_rx_reg <= {crc_rx_reg[CRC_W-2:0], bus_in};
               if (bit_cnt_reg == CRC_LAST) begin
                  state_reg   <= ST_STOP;
                  bit_cnt_reg <= '0;
               end else begin
                  bit_cnt_reg <= bit_cnt_reg + 1'b1;
               end
            end
            ST_STOP: begin
               // A high level here is a broken stop bit, never the start of the next frame.
               state_reg        <= ST_IDLE;
               busy_reg         <= 1'b0;
               bit_cnt_reg      <= '0;
               eval_pending_reg <= 1'b1;
               stop_bad_reg     <= bus_in;
               match_reg        <= (addr_sr_reg == MY_ADDR) || (addr_sr_reg == BCAST_ADDR);
               crc_ok_reg       <= (crc_rx_reg == crc_calc);
            end
            default: begin
               state_reg   <= ST_IDLE;
               busy_reg    <= 1'b0;
               bit_cnt_reg <= '0;
            end
         endcase
      end
   end

   assign rx_data   = rx_data_reg;
   assign rx_addr   = rx_addr_reg;
   assign rx_valid  = rx_valid_reg;
   assign crc_err   = crc_err_reg;
   assign frame_err = frame_err_reg;
   assign busy      = busy_reg;

endmodule

// File: tb/tb_bus_rx_node.sv
// Scoreboard bench for bus_rx_node: directed and random frames against a polynomial-division CRC model.
module tb_bus_rx_node;

   localparam logic [3:0] NODE_ADDR = 4'd1;
   localparam logic [3:0] BC_ADDR   = 4'hF;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        bus_in = 1'b0;
   logic [63:0] rx_data;
   logic [3:0]  rx_addr;
   logic        rx_valid;
   logic        crc_err;
   logic        frame_err;
   logic        busy;

   bus_rx_node #(.MY_ADDR(NODE_ADDR), .BCAST_ADDR(BC_ADDR)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .bus_in    (bus_in),
      .rx_data   (rx_data),
      .rx_addr   (rx_addr),
      .rx_valid  (rx_valid),
      .crc_err   (crc_err),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc = cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;
   int n_frames = 0;

   // kind: 0 = rx_valid, 1 = crc_err, 2 = frame_err
   typedef struct {
      int          kind;
      logic [3:0]  addr;
      logic [63:0] data;
      int          due;
   } exp_t;

   exp_t        sb[$];
   logic [63:0] model_data = '0;
   logic [3:0]  model_addr = '0;

   // Remainder of M(x)*x^4 divided by x^4+x+1.
   function automatic logic [3:0] ref_crc(input logic [67:0] m);
      logic [71:0] r;
      r = {m, 4'b0000};
      for (int i = 71; i >= 4; i--) begin
         if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
      end
      return r[3:0];
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clock);
         bus_in = 1'b0;
      end
      if (n > 0) check("busy_idle", busy, 1'b0);
   endtask

   task automatic send_frame(input logic [3:0] a, input logic [63:0] d,
                             input logic [3:0] crc_flip, input logic stop, input int abort_at);
      logic [73:0] f;
      logic [3:0]  c;
      int          s;
      int          kind;
      exp_t        e;
      c = ref_crc({a, d}) ^ crc_flip;
      f = {1'b1, a, d, c, stop};
      s = 0;
      for (int i = 0; i < 74; i++) begin
         @(negedge clock);
         if (i == 0) s = cyc + 1;
         if (i == 10) check("busy_frame", busy, 1'b1);
         if (i == abort_at) begin
            bus_in  = 1'b0;
            reset_n = 1'b0;
            #1;
            check("abort_busy", busy, 1'b0);
            check("abort_rx_data", rx_data, 64'h0);
            check("abort_rx_addr", rx_addr, 4'h0);
            check("abort_pulses", {rx_valid, crc_err, frame_err}, 3'b000);
            model_data = '0;
            model_addr = '0;
            @(negedge clock);
            reset_n = 1'b1;
            $display("frame %0d addr=%h data=%h aborted by reset at bit %0d", n_frames, a, d, i);
            n_frames++;
            return;
         end
         bus_in = f[73-i];
      end
      if (stop) kind = 2;
      else if (!(a == NODE_ADDR || a == BC_ADDR)) kind = -1;
      else if (crc_flip != 4'h0) kind = 1;
      else kind = 0;
      if (kind == 0) begin
         model_data = d;
         model_addr = a;
      end
      if (kind >= 0) begin
         e.kind = kind;
         e.addr = model_addr;
         e.data = model_data;
         e.due  = s + 74;
         sb.push_back(e);
      end
      $display("frame %0d addr=%h data=%h crc_flip=%h stop=%0d expect=%0d", n_frames, a, d, crc_flip, stop, kind);
      n_frames++;
   endtask

   // Monitor: pops the scoreboard whenever a result pulse appears.
   initial begin
      exp_t e;
      int   got_kind;
      forever begin
         @(negedge clock);
         if (reset_n && (rx_valid || crc_err || frame_err)) begin
            got_kind = rx_valid ? 0 : (crc_err ? 1 : 2);
            check("pulse_onehot", 32'(rx_valid) + 32'(crc_err) + 32'(frame_err), 1);
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_pulse: got kind %0d, expected none (cycle %0d)", got_kind, cyc);
            end else begin
               e = sb.pop_front();
               check("pulse_kind", got_kind, e.kind);
               check("pulse_cycle", cyc, e.due);
               check("rx_addr", rx_addr, e.addr);
               check("rx_data", rx_data, e.data);
            end
         end
         if (sb.size() > 0 && cyc > sb[0].due) begin
            e = sb.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL missing_pulse: got none, expected kind %0d at cycle %0d", e.kind, e.due);
         end
      end
   end

   initial begin
      logic [3:0]  ra;
      logic [63:0] rd;
      logic [3:0]  rf;
      logic        rs;
      reset_n = 1'b0;
      bus_in  = 1'b0;
      repeat (3) @(negedge clock);
      check("reset_rx_data", rx_data, 64'h0);
      check("reset_rx_addr", rx_addr, 4'h0);
      check("reset_rx_valid", rx_valid, 1'b0);
      check("reset_crc_err", crc_err, 1'b0);
      check("reset_frame_err", frame_err, 1'b0);
      check("reset_busy", busy, 1'b0);
      reset_n = 1'b1;
      idle(3);

      send_frame(4'd1, 64'h1, 4'h0, 1'b0, -1);                      idle(3);
      send_frame(4'd1, 64'h1, 4'h1, 1'b0, -1);                      idle(3);
      send_frame(4'hF, 64'hDEADBEEF_01234567, 4'h0, 1'b0, -1);      idle(3);
      send_frame(4'd2, 64'hCAFE_F00D_1234_5678, 4'h0, 1'b0, -1);    idle(3);
      send_frame(4'd1, 64'h0BAD_0BAD_0BAD_0BAD, 4'h0, 1'b1, -1);    idle(3);
      send_frame(4'd1, 64'h1111_2222_3333_4444, 4'h0, 1'b0, -1);
      send_frame(4'hF, 64'h5555_6666_7777_8888, 4'h0, 1'b0, -1);    idle(5);
      send_frame(4'd1, 64'hAAAA_BBBB_CCCC_DDDD, 4'h0, 1'b0, 30);    idle(3);
      send_frame(4'd1, 64'h9876_5432_10FE_DCBA, 4'h0, 1'b0, -1);    idle(3);

      for (int k = 0; k < 40; k++) begin
         case ($urandom_range(0, 3))
            0:       ra = NODE_ADDR;
            1:       ra = BC_ADDR;
            default: ra = 4'($urandom_range(0, 15));
         endcase
         rd = {$urandom(), $urandom()};
         rf = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
         rs = ($urandom_range(0, 6) == 0);
         send_frame(ra, rd, rf, rs, -1);
         idle($urandom_range(0, 3));
      end
      idle(2);

      for (int k = 0; k < 200 && sb.size() > 0; k++) @(negedge clock);
      check("scoreboard_drained", sb.size(), 0);
      check("final_rx_data", rx_data, model_data);
      check("final_rx_addr", rx_addr, model_addr);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
